// File: rtl/mm2s_rd_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM read port among N_REQ mm2s requesters.
// Bursts are locked to one owner; a tag pipe matched to RD_LAT routes each response back to its issuer.
module mm2s_rd_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_ren,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  output logic [OW-1:0]             owner,
  output logic                      busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   rr_ptr_q;
  logic [CW-1:0]   beat_cnt_q;
  logic [CW-1:0]   beat_cnt_d;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [OW-1:0]   tag_own_q [RD_LAT];

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [OW-1:0]   pick;
  logic            pick_found;
  logic            own_valid;
  logic            fire;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Walk rr_ptr+N .. rr_ptr+1 so the closest valid requester after rr_ptr is written last and wins.
  always_comb begin
    logic [OW-1:0] cand;
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = OW'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  assign own_valid  = req_valid[owner_q];
  assign fire       = (state_q == GRANT) && own_valid && !rst;
  assign beat_cnt_d = beat_cnt_q + CW'(1);

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[owner_q] = 1'b1;
  end

  assign mem_ren  = fire;
  assign mem_addr = fire ? addr_arr[owner_q] : '0;

  always_comb begin
    rsp_valid = '0;
    if (tag_vld_q[RD_LAT-1] && !rst) rsp_valid[tag_own_q[RD_LAT-1]] = 1'b1;
  end

  assign rsp_data = mem_data;
  assign owner    = owner_q;
  assign busy     = !rst && ((state_q == GRANT) || (|tag_vld_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= OW'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q    <= pick;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (!own_valid) begin
            state_q  <= IDLE;
            rr_ptr_q <= owner_q;
          end else begin
            beat_cnt_q <= beat_cnt_d;
            // The beat that reaches MAX_BURST is still issued this cycle.
            if (beat_cnt_d == CW'(MAX_BURST)) begin
              state_q  <= IDLE;
              rr_ptr_q <= owner_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset flushes the tag pipe so reads in flight at reset never produce a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) tag_own_q[s] <= '0;
    end else begin
      tag_vld_q[0] <= fire;
      tag_own_q[0] <= owner_q;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_own_q[s] <= tag_own_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_mm2s_rd_arbiter.sv
// Bench for mm2s_rd_arbiter: cycle table for grant/ready/response timing, plus a per-requester
// response scoreboard against an address-keyed RAM model and a random-valid phase.
module tb_mm2s_rd_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int RD_LAT = 2;
  localparam int MAXB   = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    mem_ren;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_data;
  logic [1:0]              owner;
  logic                    busy;

  mm2s_rd_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_data(mem_data), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ram_fn(input logic [ADDR_W-1:0] a);
    return {4'hA, a, 4'h5, ~a, 4'hC, a ^ 28'h1234567, 4'h3, a + 28'd1};
  endfunction

  // Requester address generators: each advances only on an accepted beat.
  logic [19:0]       cnt [N_REQ] = '{default: '0};
  logic [ADDR_W-1:0] addr_w [N_REQ];
  logic [N_REQ-1:0]  fire_q = '0;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) addr_w[i] = {8'(i + 1), cnt[i]};
  end
  assign req_addr = {addr_w[2], addr_w[1], addr_w[0]};

  always @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) if (fire_q[i]) cnt[i] <= cnt[i] + 20'd1;
  end

  // RAM model with RD_LAT-cycle read latency.
  logic [ADDR_W-1:0] mpipe [RD_LAT] = '{default: '0};
  always @(posedge clk) begin
    mpipe[0] <= mem_addr;
    for (int s = 1; s < RD_LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mem_data = ram_fn(mpipe[RD_LAT-1]);

  logic [ADDR_W-1:0] exp_q [N_REQ][$];

  always @(negedge clk) begin
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < N_REQ; i++) begin
      fire_q[i] = req_valid[i] && req_ready[i];
      if (rsp_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected req%0d: got data %0h required no response", i, rsp_data);
        end else begin
          a = exp_q[i].pop_front();
          check($sformatf("rsp_data req%0d", i), rsp_data, ram_fn(a));
        end
      end
      if (fire_q[i]) exp_q[i].push_back(addr_w[i]);
    end
    if (rst) for (int i = 0; i < N_REQ; i++) exp_q[i].delete();
  end

  typedef struct {
    bit       r;
    bit [2:0] vld;
    bit [2:0] rdy;
    bit       ren;
    bit [1:0] own;
    bit [2:0] rsp;
    bit       bsy;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit r, input bit [2:0] v, input bit [2:0] rd, input bit en,
                     input bit [1:0] ow, input bit [2:0] rs, input bit b);
    vec_t e;
    e.r = r; e.vld = v; e.rdy = rd; e.ren = en; e.own = ow; e.rsp = rs; e.bsy = b;
    tbl.push_back(e);
  endtask

  initial begin
    // single requester, 4-beat burst
    add(1, 3'b000, 3'b000, 0, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 0, 0, 3'b000, 0);
    add(0, 3'b001, 3'b001, 1, 0, 3'b000, 1);
    add(0, 3'b001, 3'b001, 1, 0, 3'b000, 1);
    add(0, 3'b001, 3'b001, 1, 0, 3'b001, 1);
    add(0, 3'b001, 3'b001, 1, 0, 3'b001, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b001, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b001, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 0);
    // all valid: grants 0,1,2,0 with forced release at MAX_BURST
    add(1, 3'b111, 3'b000, 0, 0, 3'b000, 0);
    add(0, 3'b111, 3'b000, 0, 0, 3'b000, 0);
    add(0, 3'b111, 3'b001, 1, 0, 3'b000, 1);
    add(0, 3'b111, 3'b001, 1, 0, 3'b000, 1);
    add(0, 3'b111, 3'b001, 1, 0, 3'b001, 1);
    add(0, 3'b111, 3'b001, 1, 0, 3'b001, 1);
    add(0, 3'b111, 3'b000, 0, 0, 3'b001, 1);
    add(0, 3'b111, 3'b010, 1, 1, 3'b001, 1);
    add(0, 3'b111, 3'b010, 1, 1, 3'b000, 1);
    add(0, 3'b111, 3'b010, 1, 1, 3'b010, 1);
    add(0, 3'b111, 3'b010, 1, 1, 3'b010, 1);
    add(0, 3'b111, 3'b000, 0, 0, 3'b010, 1);
    add(0, 3'b111, 3'b100, 1, 2, 3'b010, 1);
    add(0, 3'b111, 3'b100, 1, 2, 3'b000, 1);
    add(0, 3'b111, 3'b100, 1, 2, 3'b100, 1);
    add(0, 3'b111, 3'b100, 1, 2, 3'b100, 1);
    add(0, 3'b111, 3'b000, 0, 0, 3'b100, 1);
    add(0, 3'b001, 3'b001, 1, 0, 3'b100, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 1);
    // req1 drops after 2 beats while req2 waits
    add(0, 3'b110, 3'b000, 0, 0, 3'b001, 1);
    add(0, 3'b110, 3'b010, 1, 1, 3'b000, 1);
    add(0, 3'b110, 3'b010, 1, 1, 3'b000, 1);
    add(0, 3'b100, 3'b000, 0, 0, 3'b010, 1);
    add(0, 3'b100, 3'b000, 0, 0, 3'b010, 1);
    add(0, 3'b100, 3'b100, 1, 2, 3'b000, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b100, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 0);
    // req0 / req2 alternating single beats
    add(0, 3'b001, 3'b000, 0, 0, 3'b000, 0);
    add(0, 3'b001, 3'b001, 1, 0, 3'b000, 1);
    add(0, 3'b100, 3'b000, 0, 0, 3'b000, 1);
    add(0, 3'b100, 3'b000, 0, 0, 3'b001, 1);
    add(0, 3'b100, 3'b100, 1, 2, 3'b000, 1);
    add(0, 3'b001, 3'b000, 0, 0, 3'b000, 1);
    add(0, 3'b001, 3'b000, 0, 0, 3'b100, 1);
    add(0, 3'b001, 3'b001, 1, 0, 3'b000, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b001, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 0);
    // reset with reads in flight; first grant afterwards goes to req0
    add(0, 3'b010, 3'b000, 0, 0, 3'b000, 0);
    add(0, 3'b010, 3'b010, 1, 1, 3'b000, 1);
    add(0, 3'b010, 3'b010, 1, 1, 3'b000, 1);
    add(0, 3'b010, 3'b010, 1, 1, 3'b010, 1);
    add(1, 3'b010, 3'b000, 0, 0, 3'b000, 0);
    add(0, 3'b011, 3'b000, 0, 0, 3'b000, 0);
    add(0, 3'b011, 3'b001, 1, 0, 3'b000, 1);
    add(0, 3'b010, 3'b000, 0, 0, 3'b000, 1);
    add(0, 3'b010, 3'b000, 0, 0, 3'b001, 1);
    add(0, 3'b010, 3'b010, 1, 1, 3'b000, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b010, 1);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 0);

    @(posedge clk);
    foreach (tbl[c]) begin
      @(posedge clk);
      #1;
      rst       = tbl[c].r;
      req_valid = tbl[c].vld;
      @(negedge clk);
      check($sformatf("cyc%0d req_ready", c), req_ready, tbl[c].rdy);
      check($sformatf("cyc%0d mem_ren", c), mem_ren, tbl[c].ren);
      check($sformatf("cyc%0d rsp_valid", c), rsp_valid, tbl[c].rsp);
      check($sformatf("cyc%0d busy", c), busy, tbl[c].bsy);
      if (tbl[c].ren) check($sformatf("cyc%0d owner", c), owner, tbl[c].own);
      $display("cyc %0d: vld=%b rdy=%b ren=%b own=%0d rsp=%b busy=%b",
               c, req_valid, req_ready, mem_ren, owner, rsp_valid, busy);
    end

    // Random valid patterns; per-cycle protocol checks, data checked by the scoreboard.
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      req_valid = N_REQ'($urandom_range(0, 7));
      @(negedge clk);
      check("rnd ready_without_valid", req_ready & ~req_valid, '0);
      check("rnd mem_ren_vs_ready", mem_ren, |req_ready);
      check("rnd ready_onehot", $countones(req_ready) > 1, 0);
      check("rnd rsp_onehot", $countones(rsp_valid) > 1, 0);
    end

    // Drain the tag pipe within a fixed cycle budget.
    req_valid = '0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    check("drain busy", busy, 0);
    for (int i = 0; i < N_REQ; i++) check($sformatf("drain pending req%0d", i), exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
